// File: rtl/req_gnt_arbiter.sv
// Round-robin request/grant arbiter with a registered one-hot grant and a
// per-owner hold limit so that no requester can starve the others.
module req_gnt_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      req,
  output logic [N-1:0]                      gnt,
  output logic                              gnt_valid,
  output logic [IDW-1:0]                    gnt_id,
  output logic [$clog2(MAX_HOLD+1)-1:0]     hold_cnt
);

  localparam int HW = $clog2(MAX_HOLD+1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] last_id;
  logic [N-1:0]   others;
  logic           at_limit;
  logic           owner_rel;
  logic [IDW-1:0] idle_win;
  logic [IDW-1:0] hand_win;

  // First set bit of cand, searching upward from from_id+1 with wrap-around.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] cand,
                                             input logic [IDW-1:0] from_id);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(from_id) + k) % N;
      if (!found && cand[idx[IDW-1:0]]) begin
        win   = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == HOLD_LAST) ? v : v + HW'(1);
  endfunction

  always_comb begin
    others    = req & ~(ONE << gnt_id);
    at_limit  = (hold_cnt == HOLD_LAST);
    owner_rel = !req[gnt_id] || (at_limit && (|others));
    idle_win  = rr_pick(req, last_id);
    hand_win  = rr_pick(others, last_id);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
      last_id   <= IDW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            gnt       <= ONE << idle_win;
            gnt_valid <= 1'b1;
            gnt_id    <= idle_win;
            last_id   <= idle_win;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (!owner_rel) begin
            hold_cnt <= sat_inc(hold_cnt);
          end else if (|others) begin
            // Zero-gap handover: the next owner is loaded in the same edge.
            gnt       <= ONE << hand_win;
            gnt_valid <= 1'b1;
            gnt_id    <= hand_win;
            last_id   <= hand_win;
            hold_cnt  <= '0;
          end else begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
  a_idle_hs: assert property (@(posedge clk) disable iff (!rst_n)
                              (state == IDLE && (|req)) |=> gnt_valid);

  for (genvar i = 0; i < N; i++) begin : g_gnt_req
    a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
                                gnt[i] |-> $past(req[i]));
  end

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD 8 and 2) share one request
// vector and are compared each cycle against a behavioural model.
module tb_req_gnt_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;

  logic [N-1:0] g0, g1;
  logic         v0, v1;
  logic [1:0]   i0, i1;
  logic [3:0]   h0;
  logic [1:0]   h1;
  logic [10:0]  act [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_gnt_arbiter #(.N(N), .MAX_HOLD(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(g0), .gnt_valid(v0), .gnt_id(i0), .hold_cnt(h0));

  req_gnt_arbiter #(.N(N), .MAX_HOLD(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(g1), .gnt_valid(v1), .gnt_id(i1), .hold_cnt(h1));

  assign act[0] = {g0, v0, i0, h0};
  assign act[1] = {g1, v1, i1, 2'b00, h1};

  // Behavioural model: owner index (-1 = idle), pointer, hold count.
  int           mh   [2] = '{8, 2};
  int           own  [2] = '{-1, -1};
  int           last [2] = '{N-1, N-1};
  int           hold [2] = '{0, 0};
  int           idv  [2] = '{0, 0};
  int           m_w;
  logic [N-1:0] m_oth;
  logic         m_rel;

  function automatic int pick(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++)
      if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic logic [10:0] expv(input int k);
    logic [N-1:0] g;
    g = (own[k] < 0) ? '0 : 4'(1 << own[k]);
    return {g, own[k] >= 0, 2'(idv[k]), 4'(hold[k])};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        own[k] = -1; last[k] = N-1; hold[k] = 0; idv[k] = 0;
      end else if (own[k] < 0) begin
        if (req != '0) begin
          m_w = pick(req, last[k]);
          own[k] = m_w; idv[k] = m_w; last[k] = m_w; hold[k] = 0;
        end
      end else begin
        m_oth = req & ~(4'(1) << own[k]);
        m_rel = !req[own[k]] || (hold[k] == mh[k]-1 && m_oth != '0);
        if (!m_rel) begin
          if (hold[k] < mh[k]-1) hold[k] = hold[k] + 1;
        end else if (m_oth != '0) begin
          m_w = pick(m_oth, last[k]);
          own[k] = m_w; idv[k] = m_w; last[k] = m_w; hold[k] = 0;
        end else begin
          own[k] = -1; hold[k] = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (g0 !== 4'b0000 || v0 !== 1'b0 || h0 !== 4'd0 || i0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold gnt=%b vld=%b id=%0d hold=%0d want 0", g0, v0, i0, h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== expv(k)) begin
          errors++;
          $display("FAIL reset_idle inst=%0d got=%h want=%h", k, act[k], expv(k));
        end
      end
      checks++;
      if (g0 !== 4'b0000 || v0 !== 1'b0 || h0 !== 4'd0) begin
        errors++;
        $display("FAIL idle_zero cyc=%0d gnt=%b vld=%b hold=%0d want 0", c, g0, v0, h0);
      end
    end
  endtask

  task automatic test_handshake();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== expv(k)) begin
          errors++;
          $display("FAIL handshake inst=%0d cyc=%0d got=%h want=%h", k, c, act[k], expv(k));
        end
      end
      checks++;
      if (g0 !== 4'b0001 || h0 !== 4'(c)) begin
        errors++;
        $display("FAIL hs_hold cyc=%0d gnt=%b hold=%0d want 0001/%0d", c, g0, h0, c);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (g0 !== 4'b0000 || v0 !== 1'b0 || g1 !== 4'b0000) begin
      errors++;
      $display("FAIL hs_drop gnt0=%b vld0=%b gnt1=%b want 0", g0, v0, g1);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                            4'b0100, 4'b1000, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== expv(k)) begin
          errors++;
          $display("FAIL rotation inst=%0d cyc=%0d got=%h want=%h", k, c, act[k], expv(k));
        end
      end
      checks++;
      if (g1 !== seq[c]) begin
        errors++;
        $display("FAIL rr_seq cyc=%0d gnt=%b want %b", c, g1, seq[c]);
      end
    end
  endtask

  task automatic test_zero_gap();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (g0 !== 4'b0010 || g1 !== 4'b0010) begin
      errors++;
      $display("FAIL zg_owner gnt0=%b gnt1=%b want 0010", g0, g1);
    end
    req = 4'b1000;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== expv(k)) begin
        errors++;
        $display("FAIL zero_gap inst=%0d got=%h want=%h", k, act[k], expv(k));
      end
    end
    checks++;
    if (g0 !== 4'b1000 || i0 !== 2'd3 || v0 !== 1'b1 || g1 !== 4'b1000) begin
      errors++;
      $display("FAIL zg_handover gnt0=%b id0=%0d vld0=%b gnt1=%b want 1000/3/1", g0, i0, v0, g1);
    end
  endtask

  task automatic test_lone();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== expv(k)) begin
          errors++;
          $display("FAIL lone inst=%0d cyc=%0d got=%h want=%h", k, c, act[k], expv(k));
        end
      end
      checks++;
      if (g0 !== 4'b0100) begin
        errors++;
        $display("FAIL lone_gnt cyc=%0d gnt=%b want 0100", c, g0);
      end
    end
    checks++;
    if (h0 !== 4'd7 || h1 !== 2'd1) begin
      errors++;
      $display("FAIL lone_sat hold0=%0d hold1=%0d want 7/1", h0, h1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (g0 !== 4'b0000 || v0 !== 1'b0 || g1 !== 4'b0000 || v1 !== 1'b0) begin
      errors++;
      $display("FAIL async_drop gnt0=%b vld0=%b gnt1=%b vld1=%b want 0", g0, v0, g1, v1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0110;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act[k] !== expv(k)) begin
        errors++;
        $display("FAIL async_resume inst=%0d got=%h want=%h", k, act[k], expv(k));
      end
    end
    checks++;
    if (g0 !== 4'b0010 || g1 !== 4'b0010) begin
      errors++;
      $display("FAIL async_first gnt0=%b gnt1=%b want 0010", g0, g1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act[k] !== expv(k)) begin
          errors++;
          $display("FAIL random inst=%0d cyc=%0d req=%b got=%h want=%h", k, c, req, act[k], expv(k));
        end
      end
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_rotation();
    test_zero_gap();
    test_lone();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_gnt_arbiter.md
Name: req_gnt_arbiter

Overview:
- Round-robin arbiter that produces the registered grant checked by the req/gnt handshake property (req |=> gnt).
- Accepts N independent request lines and returns a one-hot registered grant.
- An idle arbiter grants exactly one cycle after a request is sampled.
- Sits directly upstream of the handshake checker and the shared-resource consumer; a hold limit stops any requester from starving the others.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per owner while others wait (>=1).
- IDW, $clog2(N), width of the grant index.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request vector; bit i held high by requester i while it wants the resource.
- gnt  out  N  registered one-hot grant (all-zero when idle).
- gnt_valid  out  1  registered; equals |gnt.
- gnt_id  out  IDW  registered index of the owner; valid only when gnt_valid=1.
- hold_cnt  out  $clog2(MAX_HOLD+1)  registered count of completed grant cycles for the current owner.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, state=IDLE.
  - Round-robin pointer last_id = N-1, so the first arbitration after reset favours requester 0.
- Reset asserted mid-grant drops gnt immediately, without waiting for a clock edge.
- States: IDLE and GRANT. All outputs are flops; no combinational path from req to gnt.
- Round-robin pick: search indices last_id+1, last_id+2, ... mod N; the first index with req set wins. This gives wrap-around from N-1 to 0.
- IDLE:
  - If |req at a posedge: load the winner into gnt/gnt_id, set hold_cnt=0, last_id=winner, go to GRANT. gnt rises one cycle after req.
  - Otherwise stay in IDLE with gnt=0.
- GRANT, evaluated at each posedge with owner = gnt_id:
  - Release when req[owner]=0. Also release when hold_cnt==MAX_HOLD-1 and some other req[j]=1, j!=owner (expiry).
  - No release: keep gnt. hold_cnt increments, saturating at MAX_HOLD-1 when no other requester is waiting. A lone requester therefore keeps the grant indefinitely.
  - Release with a candidate: a candidate is any req[j]=1 with j!=owner, or the owner itself only on a voluntary drop (it cannot be, since its req is 0). Re-arbitrate immediately: the new winner owns gnt at the next cycle with no idle gap, hold_cnt=0, last_id=winner.
  - Release with no candidate: gnt=0, gnt_valid=0, go to IDLE. gnt_id keeps its last value.
- Simultaneous events:
  - Owner drops req while others request: the handover is zero-gap. Exactly one gnt bit is high in every cycle; gnt never has two bits set.
  - Owner's req re-rises in the same cycle its grant was released: no priority; it waits for its round-robin turn.
- One-hot invariant: $onehot0(gnt) every cycle. gnt_valid == |gnt. gnt[i] implies req[i] was high at the previous posedge.
- Single-requester handshake: req[i] rising at posedge k, with the arbiter idle or the current owner releasing at k, gives gnt[i]=1 at posedge k+1.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then req=0 for 5 cycles -> gnt=0, gnt_valid=0, hold_cnt=0 throughout.
- Single handshake: req=4'b0001 at cycle 2, held 4 cycles, then dropped:
  - gnt=4'b0001 from cycle 3 through cycle 6; gnt=0 at cycle 7.
  - hold_cnt counts 0,1,2,3.
  - req|=>gnt assertion passes.
- Round-robin rotation: req=4'b1111 held, MAX_HOLD=2:
  - gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; wraps from 3 to 0 with no idle cycle.
- Zero-gap handover: owner 1 (gnt=0010) drops req[1] in the same cycle req[3] rises -> next cycle gnt=1000, gnt_id=3, never 0000 and never two bits set.
- Lone requester with no expiry: req=4'b0100 held 20 cycles, MAX_HOLD=8 -> gnt=0100 continuous; hold_cnt saturates at 7.
- Async reset mid-grant: while gnt=0010, pulse rst_n low between edges:
  - gnt=0 immediately.
  - After release with req=4'b0110, the first grant is 0010 (pointer reset favours the lowest index).
